// File: rtl/cpu_debug_unit_pkg.sv
// cpu_debug_unit_pkg: shared FSM states, display selects and control-word width
package cpu_debug_unit_pkg;
  localparam int CTRL_W = 10;
  typedef enum logic [1:0] {HALT, RUN, STEP, WAIT} state_t;
  localparam logic [2:0] SEL_DBG   = 3'd0;
  localparam logic [2:0] SEL_NPC   = 3'd1;
  localparam logic [2:0] SEL_PC    = 3'd2;
  localparam logic [2:0] SEL_INSTR = 3'd3;
  localparam logic [2:0] SEL_RS    = 3'd4;
  localparam logic [2:0] SEL_RT    = 3'd5;
  localparam logic [2:0] SEL_ALU   = 3'd6;
  localparam logic [2:0] SEL_MRD   = 3'd7;
endpackage

// File: rtl/cpu_debug_unit_if.sv
// cpu_debug_unit_if: CPU-side bus between the debug unit (master) and the CPU datapath (slave)
interface cpu_debug_unit_if #(parameter int WIDTH = 32, parameter int MADDR_W = 8, parameter int RADDR_W = 5);
  import cpu_debug_unit_pkg::*;
  logic               cpu_en;
  logic [WIDTH-1:0]   pc_in;
  logic [WIDTH-1:0]   npc_in;
  logic [WIDTH-1:0]   instr_in;
  logic [CTRL_W-1:0]  ctrl_in;
  logic [WIDTH-1:0]   rs_in;
  logic [WIDTH-1:0]   rt_in;
  logic [WIDTH-1:0]   alu_in;
  logic [WIDTH-1:0]   mrd_in;
  logic [RADDR_W-1:0] dbg_ra;
  logic [WIDTH-1:0]   dbg_rd;
  logic [MADDR_W-1:0] dbg_ma;
  logic [WIDTH-1:0]   dbg_md;
  modport master (
    output cpu_en, dbg_ra, dbg_ma,
    input  pc_in, npc_in, instr_in, ctrl_in, rs_in, rt_in, alu_in, mrd_in, dbg_rd, dbg_md
  );
  modport slave (
    input  cpu_en, dbg_ra, dbg_ma,
    output pc_in, npc_in, instr_in, ctrl_in, rs_in, rt_in, alu_in, mrd_in, dbg_rd, dbg_md
  );
endinterface

// File: rtl/cpu_debug_unit_btn_sync.sv
// cpu_debug_unit_btn_sync: 2-flop synchronizer plus rising-edge one-cycle pulse
module cpu_debug_unit_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);
  logic r_meta, r_sync, r_prev;
  // synchronize the async button and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_meta, r_sync, r_prev} <= '0;
    else {r_meta, r_sync, r_prev} <= {i_btn, r_meta, r_sync};
  assign o_level = r_sync;
  assign o_pulse = r_sync & ~r_prev;
endmodule

// File: rtl/cpu_debug_unit.sv
// cpu_debug_unit: CPU clock-enable gating (run/step) and architectural-state readback display
module cpu_debug_unit
  import cpu_debug_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MADDR_W = 8,
  parameter int RADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic              m_rf,
  input  logic [2:0]        sel,
  cpu_debug_unit_if.master  bus,
  output logic [WIDTH-1:0]  disp,
  output logic [15:0]       led
);
  state_t             r_state, w_next;
  logic               r_cpu_en, r_run_meta, r_run_s;
  logic               w_step_s, w_step_p, w_inc_p, w_dec_p;
  logic [1:0]         w_unused_lvl;
  logic [MADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]   w_disp;
  logic [15:0]        w_led;

  cpu_debug_unit_btn_sync u_step (.clk(clk), .rst(rst), .i_btn(step), .o_level(w_step_s),        .o_pulse(w_step_p));
  cpu_debug_unit_btn_sync u_inc  (.clk(clk), .rst(rst), .i_btn(inc),  .o_level(w_unused_lvl[0]), .o_pulse(w_inc_p));
  cpu_debug_unit_btn_sync u_dec  (.clk(clk), .rst(rst), .i_btn(dec),  .o_level(w_unused_lvl[1]), .o_pulse(w_dec_p));

  // run is a level switch, so it only needs the synchronizer, no edge detect
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_run_meta, r_run_s} <= '0;
    else {r_run_meta, r_run_s} <= {run, r_run_meta};

  // next-state logic; run always wins, WAIT holds until the step button is released
  always_comb begin
    w_next = r_state;
    case (r_state)
      HALT:    w_next = r_run_s ? RUN : w_step_p ? STEP : HALT;
      RUN:     w_next = r_run_s ? RUN : HALT;
      STEP:    w_next = WAIT;
      WAIT:    w_next = r_run_s ? RUN : w_step_s ? WAIT : HALT;
      default: w_next = HALT;
    endcase
  end

  // state register with registered cpu_en so the enable is glitch-free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= HALT;
      r_cpu_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cpu_en <= (w_next == RUN) || (w_next == STEP);
    end

  // debug address counter; simultaneous inc and dec cancel out, wraps naturally
  always_ff @(posedge clk or posedge rst)
    if (rst) r_addr <= '0;
    else r_addr <= r_addr + MADDR_W'(w_inc_p) - MADDR_W'(w_dec_p);

  // display source select
  always_comb begin
    w_disp = '0;
    case (sel)
      SEL_DBG:   w_disp = m_rf ? bus.dbg_md : bus.dbg_rd;
      SEL_NPC:   w_disp = bus.npc_in;
      SEL_PC:    w_disp = bus.pc_in;
      SEL_INSTR: w_disp = bus.instr_in;
      SEL_RS:    w_disp = bus.rs_in;
      SEL_RT:    w_disp = bus.rt_in;
      SEL_ALU:   w_disp = bus.alu_in;
      SEL_MRD:   w_disp = bus.mrd_in;
      default:   w_disp = '0;
    endcase
  end

  assign w_led = (sel != SEL_DBG) ? {bus.ctrl_in, 6'b0} : {m_rf, 7'b0, 8'(r_addr)};

  // display and led registers, refreshed every cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp <= '0;
      led  <= '0;
    end else begin
      disp <= w_disp;
      led  <= w_led;
    end

  assign bus.cpu_en = r_cpu_en;
  assign bus.dbg_ma = r_addr;
  assign bus.dbg_ra = r_addr[RADDR_W-1:0];
endmodule

// File: tb/tb_cpu_debug_unit.sv
// tb_cpu_debug_unit: directed self-checking bench with a display scoreboard
module tb_cpu_debug_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, step = 1'b0, inc = 1'b0, dec = 1'b0, m_rf = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [31:0] disp;
  logic [15:0] led;
  logic [31:0] rf_m [32];
  logic [31:0] mem_m [256];
  logic [31:0] sb [$];
  logic [31:0] tab [8];
  int total = 0, bad = 0;
  int ones, first_one, first_zero;

  cpu_debug_unit_if bus ();

  cpu_debug_unit dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .inc(inc), .dec(dec),
    .m_rf(m_rf), .sel(sel), .bus(bus), .disp(disp), .led(led)
  );

  assign bus.dbg_rd = rf_m[bus.dbg_ra];
  assign bus.dbg_md = mem_m[bus.dbg_ma];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_pop(input string tag);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else chk(tag, disp, sb.pop_front());
  endtask

  task automatic run_cycles(input int n, output int n_ones, output int f_one, output int f_zero);
    n_ones = 0;
    f_one = 0;
    f_zero = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bus.cpu_en) begin
        n_ones++;
        if (f_one == 0) f_one = i;
      end else if (f_zero == 0) f_zero = i;
    end
  endtask

  task automatic press(input logic p_inc, input logic p_dec);
    inc = p_inc;
    dec = p_dec;
    repeat (4) tick();
    inc = 1'b0;
    dec = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'hB000_0000 + i;
    rf_m[5] = 32'h0000_1234;
    mem_m[5] = 32'hDEAD_BEEF;
    tab[0] = 32'h0;
    tab[1] = 32'h0000_0004;
    tab[2] = 32'h0000_0000;
    tab[3] = 32'h2008_0003;
    tab[4] = 32'h0000_0011;
    tab[5] = 32'h0000_0022;
    tab[6] = 32'h0000_0033;
    tab[7] = 32'h0000_0044;
    bus.npc_in = tab[1];
    bus.pc_in = tab[2];
    bus.instr_in = tab[3];
    bus.rs_in = tab[4];
    bus.rt_in = tab[5];
    bus.alu_in = tab[6];
    bus.mrd_in = tab[7];
    bus.ctrl_in = 10'h2AB;
    repeat (2) tick();
    chk("reset_cpu_en", bus.cpu_en, 0);
    chk("reset_disp", disp, 0);
    chk("reset_led", led, 0);
    chk("reset_dbg_ma", bus.dbg_ma, 0);
    rst = 1'b0;
    tick();

    step = 1'b1;
    run_cycles(20, ones, first_one, first_zero);
    chk("step1_pulses", ones, 1);
    chk("step1_latency", first_one, 3);
    step = 1'b0;
    repeat (5) tick();
    step = 1'b1;
    run_cycles(10, ones, first_one, first_zero);
    chk("step2_pulses", ones, 1);
    chk("step2_latency", first_one, 3);
    step = 1'b0;
    repeat (5) tick();

    run = 1'b1;
    run_cycles(8, ones, first_one, first_zero);
    chk("run_start", first_one, 3);
    chk("run_ones", ones, 6);
    step = 1'b1;
    run_cycles(8, ones, first_one, first_zero);
    chk("run_step_ignored", ones, 8);
    step = 1'b0;
    repeat (4) tick();
    run = 1'b0;
    run_cycles(6, ones, first_one, first_zero);
    chk("run_stop_edge", first_zero, 3);
    chk("run_stop_ones", ones, 2);

    press(1'b0, 1'b1);
    chk("wrap_dec_ma", bus.dbg_ma, 255);
    chk("wrap_dec_ra", bus.dbg_ra, 31);
    press(1'b1, 1'b0);
    chk("wrap_inc_ma", bus.dbg_ma, 0);
    press(1'b1, 1'b1);
    chk("inc_dec_same", bus.dbg_ma, 0);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    chk("addr5_ma", bus.dbg_ma, 5);
    chk("addr5_ra", bus.dbg_ra, 5);

    m_rf = 1'b0;
    sel = 3'd0;
    sb.push_back(32'h0000_1234);
    tick();
    sb_pop("readback_rf");
    chk("led_rf_view", led, 16'h0005);
    m_rf = 1'b1;
    sb.push_back(32'hDEAD_BEEF);
    tick();
    sb_pop("readback_mem");
    chk("led_mem_view", led, 16'h8005);

    for (int s = 1; s < 8; s++) begin
      sel = 3'(s);
      sb.push_back(tab[s]);
      tick();
      sb_pop($sformatf("mux_sel%0d", s));
    end
    chk("led_ctrl", led, 16'hAAC0);

    run = 1'b1;
    repeat (6) tick();
    chk("pre_rst_run", bus.cpu_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_en_async", bus.cpu_en, 0);
    chk("rst_disp", disp, 0);
    chk("rst_addr", bus.dbg_ma, 0);
    run = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    run_cycles(6, ones, first_one, first_zero);
    chk("post_rst_halt", ones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
